// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a byte FIFO
// Optional drop counter output enabled by UART_TX_DROP_COUNT_EN.
module mmio_uart_tx #(
    parameter logic [31:0] UART_ADDR       = 32'hF6FFF000,
    parameter logic [15:0] CLKS_PER_BIT    = 16'd868,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_data,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        fifo_empty
`ifdef UART_TX_DROP_COUNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = (FIFO_DEPTH_LOG2)'(1);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE    = (FIFO_DEPTH_LOG2+1)'(1);
    localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic [7:0]                 mem [DEPTH];
    logic [15:0]                baud_cnt;
    logic [15:0]                baud_cnt_next;
    logic [2:0]                 bit_idx;
    logic [2:0]                 bit_idx_next;
    logic [7:0]                 shift_reg;
    logic [7:0]                 shift_next;
    logic                       tx_next;
    logic                       push_req;
    logic                       push;
    logic                       pop;
    logic                       bit_end;
    logic                       unused_data_hi;

    assign unused_data_hi = ^w_data[31:8];

    assign push_req   = we && (w_addr == UART_ADDR);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    // A push into a full FIFO still lands when the serializer pops on the same edge.
    assign push       = push_req && (!fifo_full || pop);
    assign bit_end    = (baud_cnt == CLKS_PER_BIT - 16'd1);
    assign tx_busy    = (state != IDLE) || !fifo_empty;

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 16'd1;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        tx_next       = uart_tx;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                tx_next       = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = DATA;
                    tx_next       = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued frames leave no idle gap.
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
                tx_next       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            uart_tx   <= tx_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset; entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_data[7:0];
        end
    end

`ifdef UART_TX_DROP_COUNT_EN
    logic drop;
    assign drop = push_req && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [31:0] UART_ADDR = 32'hF6FFF000;
    localparam int          CPB       = 4;
    localparam int          DEPTH     = 4;
    localparam int          FRAME     = 10 * CPB;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        uart_tx;
    logic        tx_busy;
    logic        fifo_full;
    logic        fifo_empty;
`ifdef UART_TX_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    mmio_uart_tx #(
        .UART_ADDR      (UART_ADDR),
        .CLKS_PER_BIT   (16'd4),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty)
`ifdef UART_TX_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus a frame timeline in edge numbers.
    logic [7:0] mq[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_log[$];
    int         edge_n  = 0;
    int         m_end   = 0;
    bit         m_idle  = 1;
    logic [7:0] m_drops = 8'h00;

    always @(posedge clk) begin
        bit pop_now;
        bit push_now;
        edge_n++;
        if (!rst) begin
            mq.delete();
            exp_tx.delete();
            m_idle  = 1;
            m_drops = 8'h00;
        end else begin
            if (!m_idle && edge_n == m_end) m_idle = 1;
            pop_now  = m_idle && (mq.size() > 0);
            push_now = we && (w_addr == UART_ADDR);
            if (push_now && mq.size() == DEPTH && !pop_now) begin
                if (m_drops != 8'hFF) m_drops = m_drops + 8'd1;
                push_now = 0;
            end
            if (pop_now) begin
                exp_tx.push_back(mq.pop_front());
                m_idle = 0;
                m_end  = edge_n + FRAME;
            end
            if (push_now) mq.push_back(w_data[7:0]);
        end
    end

    // Status checker and line decoder, both sampled on the falling edge.
    int   ncyc       = 0;
    bit   mon_active = 0;
    int   mon_pos    = 0;
    logic mon_s [FRAME];
    int   frames     = 0;
    int   start_q[$];
    int   end_q[$];
    bit   saw_full   = 0;

    always @(negedge clk) begin
        ncyc++;
        if (fifo_full) saw_full = 1;
        if (!rst) begin
            chk("rst_uart_tx", uart_tx, 1);
            chk("rst_fifo_empty", fifo_empty, 1);
            chk("rst_tx_busy", tx_busy, 0);
            mon_active = 0;
        end else begin
            chk("fifo_empty", fifo_empty, mq.size() == 0);
            chk("fifo_full", fifo_full, mq.size() == DEPTH);
            chk("tx_busy", tx_busy, !m_idle || mq.size() > 0);
`ifdef UART_TX_DROP_COUNT_EN
            chk("drop_count", drop_count, m_drops);
`endif
            if (!mon_active) begin
                if (uart_tx == 1'b0) begin
                    mon_active = 1;
                    mon_pos    = 1;
                    mon_s[0]   = 1'b0;
                    start_q.push_back(ncyc);
                end
            end else begin
                mon_s[mon_pos] = uart_tx;
                mon_pos++;
                if (mon_pos == FRAME) begin
                    logic [7:0] b;
                    bit         steady;
                    steady = 1;
                    for (int i = 0; i < 10; i++)
                        for (int k = 1; k < CPB; k++)
                            if (mon_s[i*CPB+k] !== mon_s[i*CPB]) steady = 0;
                    for (int i = 0; i < 8; i++) b[i] = mon_s[(i+1)*CPB];
                    chk("frame_bits_steady", steady, 1);
                    chk("frame_stop_bit", mon_s[9*CPB], 1);
                    if (exp_tx.size() == 0) begin
                        chk("frame_unexpected", 1, 0);
                    end else begin
                        chk("frame_byte", b, exp_tx.pop_front());
                    end
                    rx_log.push_back(b);
                    end_q.push_back(ncyc);
                    frames++;
                    mon_active = 0;
                end
            end
        end
    end

    task automatic drive(input logic w, input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        #1;
        we        = w;
        w_addr    = a;
        w_data    = $urandom;
        w_data[7:0] = d;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done;
        done = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (m_idle && mq.size() == 0 && exp_tx.size() == 0 && !mon_active) begin
                done = 1;
                break;
            end
        end
        chk("drain_timeout", done, 1);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [7:0]  d;
        int          exp_frames;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [9:0] pat;
        logic       got [FRAME];
        int         f0;
        int         idx0;

        rst    = 1'b0;
        we     = 1'b0;
        w_addr = '0;
        w_data = '0;

        vt[0] = '{1'b1, UART_ADDR,                  8'h3C, 1};
        vt[1] = '{1'b1, UART_ADDR + 32'd4,          8'h11, 0};
        vt[2] = '{1'b0, UART_ADDR,                  8'h11, 0};
        vt[3] = '{1'b1, UART_ADDR ^ 32'h8000_0000,  8'h22, 0};
        vt[4] = '{1'b1, UART_ADDR,                  8'h00, 1};
        vt[5] = '{1'b1, UART_ADDR,                  8'hFF, 1};
        vt[6] = '{1'b1, UART_ADDR - 32'd1,          8'h5A, 0};

        repeat (3) @(negedge clk);
        chk("reset_uart_tx", uart_tx, 1);
        chk("reset_fifo_empty", fifo_empty, 1);
        chk("reset_fifo_full", fifo_full, 0);
        chk("reset_tx_busy", tx_busy, 0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single A5 frame: latency and exact bit pattern.
        pat = 10'b11_0100_1010;
        drive(1'b1, UART_ADDR, 8'hA5);
        @(negedge clk);
        chk("a5_line_before_start", uart_tx, 1);
        chk("a5_fifo_loaded", fifo_empty, 0);
        #1 we = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            got[i] = uart_tx;
        end
        for (int i = 0; i < FRAME; i++) chk($sformatf("a5_sample%0d", i), got[i], pat[i / CPB]);
        @(negedge clk);
        chk("a5_busy_after", tx_busy, 0);
        chk("a5_line_idle_after", uart_tx, 1);

        // Table of single stores: decode hit vs. miss.
        for (int v = 0; v < 7; v++) begin
            f0 = frames;
            drive(vt[v].w, vt[v].a, vt[v].d);
            @(negedge clk);
            chk($sformatf("vec%0d_empty", v), fifo_empty, vt[v].exp_frames == 0);
            #1 we = 1'b0;
            repeat (50) @(negedge clk);
            chk($sformatf("vec%0d_frames", v), frames - f0, vt[v].exp_frames);
        end

        // Four back-to-back frames with no idle gap.
        wait_idle(500);
        idx0 = start_q.size();
        f0   = frames;
        for (int k = 1; k <= 4; k++) drive(1'b1, UART_ADDR, 8'(k));
        idle_bus();
        wait_idle(500);
        chk("b2b_frames", frames - f0, 4);
        if (start_q.size() >= idx0 + 4 && end_q.size() >= idx0 + 4) begin
            for (int k = 1; k < 4; k++)
                chk($sformatf("b2b_gap%0d", k), start_q[idx0+k] - end_q[idx0+k-1], 1);
            chk("b2b_total", end_q[idx0+3] - start_q[idx0] + 1, 4 * FRAME);
        end else begin
            chk("b2b_frame_log", start_q.size(), idx0 + 4);
        end

        // Overflow: six consecutive stores, one must be dropped.
        f0       = frames;
        saw_full = 0;
        for (int k = 0; k < 6; k++) drive(1'b1, UART_ADDR, 8'h10 + 8'(k));
        idle_bus();
        wait_idle(800);
        chk("ovf_frames", frames - f0, 5);
        chk("ovf_saw_full", saw_full, 1);
        chk("ovf_last_byte", rx_log[$], 8'h14);
`ifdef UART_TX_DROP_COUNT_EN
        chk("ovf_drop_count", drop_count, 8'd1);
`endif

        // Full FIFO, push lands on the same edge as the STOP-end pop.
        f0 = frames;
        for (int k = 0; k < 5; k++) drive(1'b1, UART_ADDR, 8'h20 + 8'(k));
        idle_bus();
        for (int k = 0; k < 200; k++) begin
            if (edge_n + 1 == m_end) break;
            @(negedge clk);
        end
        chk("stop_align", edge_n + 1 == m_end, 1);
        chk("pre_pop_full", fifo_full, 1);
        #1;
        we     = 1'b1;
        w_addr = UART_ADDR;
        w_data = 32'h0000_0025;
        @(negedge clk);
        chk("same_edge_full", fifo_full, 1);
        #1 we = 1'b0;
        wait_idle(800);
        chk("same_edge_frames", frames - f0, 6);
        chk("same_edge_last", rx_log[$], 8'h25);

        // Reset during bit 3 with two bytes queued.
        f0 = frames;
        drive(1'b1, UART_ADDR, 8'h37);
        drive(1'b1, UART_ADDR, 8'h41);
        drive(1'b1, UART_ADDR, 8'h42);
        idle_bus();
        repeat (16) @(negedge clk);
        chk("mid_bit3_low", uart_tx, 0);
        #2 rst = 1'b0;
        #1;
        chk("abort_line_high", uart_tx, 1);
        chk("abort_fifo_empty", fifo_empty, 1);
        chk("abort_not_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (150) @(negedge clk);
        chk("abort_no_frames", frames - f0, 0);
        chk("abort_line_idle", uart_tx, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            int gap;
            int burst;
            gap   = $urandom_range(0, 25);
            burst = $urandom_range(1, 5);
            repeat (gap) @(negedge clk);
            for (int j = 0; j < burst; j++) begin
                int sel;
                sel = $urandom_range(0, 9);
                drive(sel != 9,
                      (sel < 7) ? UART_ADDR : ((sel == 7) ? UART_ADDR + 32'd4 : $urandom),
                      8'($urandom));
            end
            idle_bus();
        end
        wait_idle(4000);
        chk("final_model_drained", exp_tx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter UART_ADDR, default 32'hF6FFF000, meaning the byte address whose store enqueues a TX byte.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16'd868, meaning clocks per serial bit (range 2..65535).
REQ-003 The block SHALL have parameter FIFO_DEPTH_LOG2, default 4, meaning log2 of the FIFO entries (16 entries).
REQ-004 The block SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning the asynchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port we, input, 1, meaning the RAM write strobe from the CPU memory-access stage.
REQ-007 The block SHALL have port w_addr, input, 32, meaning the store address, shared with the RAM write port.
REQ-008 The block SHALL have port w_data, input, 32, meaning the store data; only bits [7:0] are used.
REQ-009 The block SHALL have port uart_tx, output, 1, meaning the serial line, 8N1, idle high.
REQ-010 The block SHALL have port tx_busy, output, 1, meaning high while a frame is on the line or the FIFO is non-empty.
REQ-011 The block SHALL have port fifo_full, output, 1, meaning high when the FIFO holds 2^FIFO_DEPTH_LOG2 entries.
REQ-012 The block SHALL have port fifo_empty, output, 1, meaning high when the FIFO holds 0 entries.

Function
REQ-013 A push SHALL occur on a clock edge where we=1 and w_addr==UART_ADDR (full 32-bit compare), writing w_data[7:0] at the tail.
REQ-014 A push while full with no same-edge pop SHALL be dropped silently; FIFO contents and count SHALL be unchanged.
REQ-015 A push and a pop on the same edge SHALL both take effect; the count is unchanged, including when full.
REQ-016 The read and write pointers SHALL be FIFO_DEPTH_LOG2 bits wide and wrap modulo the depth; the count SHALL be FIFO_DEPTH_LOG2+1 bits wide.
REQ-017 The serializer FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-018 IDLE: uart_tx=1; on an edge with the FIFO non-empty, the FSM SHALL pop the head into an 8-bit shift register and enter START.
REQ-019 START: uart_tx=0 for exactly CLKS_PER_BIT clocks, then the FSM SHALL enter DATA.
REQ-020 DATA: 8 bits SHALL be sent LSB first, each held for exactly CLKS_PER_BIT clocks, tracked by a 3-bit bit index; after bit 7 the FSM SHALL enter STOP.
REQ-021 STOP: uart_tx=1 for CLKS_PER_BIT clocks; at its end the FSM SHALL pop and enter START if the FIFO is non-empty, else enter IDLE, so back-to-back frames have no idle gap.
REQ-022 Latency: with the FIFO empty and the FSM in IDLE, the start bit SHALL first appear on uart_tx one clock after the edge that captured the push.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT clocks; the baud counter is 16 bits and reloads to 0 on every bit boundary.
REQ-024 uart_tx SHALL be a registered output with no combinational path from the inputs.
REQ-025 tx_busy SHALL equal (state!=IDLE) | ~fifo_empty.

Reset
REQ-026 With rst=0 (asynchronous), the block SHALL force: FSM=IDLE, uart_tx=1, pointers, count, baud counter and bit index=0, fifo_empty=1, fifo_full=0, tx_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with uart_tx=1, discard the FIFO contents, and resume operation on the first edge after rst returns to 1.
REQ-028 FIFO storage RAM SHALL NOT require reset; its contents are unobservable while the count is 0.

Configuration
REQ-029 When macro UART_TX_DROP_COUNT_EN is defined, the block SHALL add output port drop_count, 8 bits, incremented on each push dropped per REQ-014, saturating at 8'hFF and reset to 0.
REQ-030 When UART_TX_DROP_COUNT_EN is undefined, port drop_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=2)
REQ-031 Reset release, store 8'hA5 to UART_ADDR -> uart_tx low the next clock; observed bits 0,1,0,1,0,0,1,0,1 then stop=1, each 4 clocks, frame 40 clocks; tx_busy then falls to 0.
REQ-032 Store 8'h11 to UART_ADDR+4 and to UART_ADDR with we=0 -> no frame; fifo_empty stays 1.
REQ-033 Four stores 01,02,03,04 on consecutive edges -> four frames in order, no idle gap between them, total 160 clocks.
REQ-034 Six stores on consecutive edges with the FSM busy -> exactly 4 bytes transmitted after the first pop, fifo_full=1 observed; with UART_TX_DROP_COUNT_EN, drop_count=1.
REQ-035 With the FIFO full, push on the same edge as the STOP-end pop -> push accepted, count stays 4, byte sent in order.
REQ-036 rst=0 during bit 3 of a frame with 2 bytes queued -> uart_tx=1 immediately, fifo_empty=1, no further frames after release.
